// File: rtl/rv32_test_ctrl.sv
// Test harness controller for an rv32 core: holds the core in reset, runs it,
// watches stores to the tohost mailbox and latches the pass/fail/timeout verdict.
module rv32_test_ctrl #(
    parameter int          RST_CYCLES  = 4,
    parameter int          TIMEOUT     = 100,
    parameter int          CNT_W       = 32,
    parameter int          DATA_W      = 32,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mon_valid,
    input  logic [31:0]       mon_addr,
    input  logic [DATA_W-1:0] mon_wdata,
    output logic              core_reset,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [DATA_W-1:0] exit_code,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0]       HOLD_INIT = 8'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

    state_t            state, state_nx;
    logic [7:0]        hold_cnt, hold_nx;
    logic [CNT_W-1:0]  cnt_nx;
    logic              pass_nx, fail_nx, timeout_nx;
    logic [DATA_W-1:0] exit_nx;
    logic              hit;

    // mon_valid is a qualify-only strobe: a store is observed in the cycle it is
    // high, there is no ready/backpressure, and it only matters while in RUN.
    assign hit = mon_valid && (mon_addr == TOHOST_ADDR) && (mon_wdata != '0);

    always_comb begin
        state_nx   = state;
        hold_nx    = hold_cnt;
        cnt_nx     = cycle_count;
        pass_nx    = pass;
        fail_nx    = fail;
        timeout_nx = timeout;
        exit_nx    = exit_code;
        case (state)
            HOLD: begin
                if (hold_cnt == 8'd0) state_nx = RUN;
                else                  hold_nx  = hold_cnt - 8'd1;
            end
            RUN: begin
                if (hit) begin
                    state_nx = DONE;
                    if (mon_wdata == DATA_W'(1)) begin
                        pass_nx = 1'b1;
                        exit_nx = '0;
                    end else begin
                        fail_nx = 1'b1;
                        exit_nx = mon_wdata >> 1;
                    end
                end else if (cycle_count == CNT_LAST) begin
                    // Count stays at its last value so it never wraps.
                    state_nx   = DONE;
                    timeout_nx = 1'b1;
                    fail_nx    = 1'b1;
                end else begin
                    cnt_nx = cycle_count + CNT_W'(1);
                end
            end
            DONE: begin
                state_nx = DONE;
            end
            default: begin
                state_nx = HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= HOLD;
            hold_cnt    <= HOLD_INIT;
            cycle_count <= '0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            exit_code   <= '0;
        end else begin
            state       <= state_nx;
            hold_cnt    <= hold_nx;
            cycle_count <= cnt_nx;
            pass        <= pass_nx;
            fail        <= fail_nx;
            timeout     <= timeout_nx;
            exit_code   <= exit_nx;
        end
    end

    // Status decoded from the registered state only; the core is frozen outside RUN.
    assign core_reset = (state != RUN);
    assign running    = (state == RUN);
    assign done       = (state == DONE);
    assign state_dbg  = state;

endmodule

// File: tb/tb_rv32_test_ctrl.sv
// Directed bench for rv32_test_ctrl: reset/hold timing, pass, fail, timeout,
// ignored stores, hit-vs-timeout priority and mid-run reset.
module tb_rv32_test_ctrl;

    logic        clk;
    logic        reset;
    logic        mon_valid;
    logic [31:0] mon_addr;
    logic [31:0] mon_wdata;
    logic        core_reset, running, done, pass, fail, timeout;
    logic [31:0] cycle_count;
    logic [31:0] exit_code;
    logic [1:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    rv32_test_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .mon_valid  (mon_valid),
        .mon_addr   (mon_addr),
        .mon_wdata  (mon_wdata),
        .core_reset (core_reset),
        .running    (running),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .timeout    (timeout),
        .cycle_count(cycle_count),
        .exit_code  (exit_code),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock edge, then settle away from the edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        mon_valid = 1'b1;
        mon_addr  = addr;
        mon_wdata = data;
        step(1);
        mon_valid = 1'b0;
        mon_addr  = '0;
        mon_wdata = '0;
    endtask

    // flags packed as {core_reset,running,done,pass,fail,timeout}
    function automatic logic [5:0] flags();
        return {core_reset, running, done, pass, fail, timeout};
    endfunction

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk({tag, "_rst_flags"}, 64'(flags()), 64'b100000);
        chk({tag, "_rst_cnt"},   64'(cycle_count), 64'd0);
        chk({tag, "_rst_exit"},  64'(exit_code), 64'd0);
        chk({tag, "_rst_state"}, 64'(state_dbg), 64'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic to_run(input string tag);
        do_reset(tag);
        step(4);
        chk({tag, "_run_entry"}, 64'(flags()), 64'b010000);
        chk({tag, "_run_cnt0"},  64'(cycle_count), 64'd0);
    endtask

    initial begin
        reset     = 1'b0;
        mon_valid = 1'b0;
        mon_addr  = '0;
        mon_wdata = '0;
        #12;

        // timeout after 100 RUN cycles with no stores
        do_reset("to");
        step(3);
        chk("to_hold3", 64'(flags()), 64'b100000);
        step(1);
        chk("to_run_flags", 64'(flags()), 64'b010000);
        chk("to_run_cnt0",  64'(cycle_count), 64'd0);
        step(99);
        chk("to_cnt99",     64'(cycle_count), 64'd99);
        chk("to_still_run", 64'(flags()), 64'b010000);
        step(1);
        chk("to_done_flags", 64'(flags()), 64'b101011);
        chk("to_done_cnt",   64'(cycle_count), 64'd99);
        chk("to_done_exit",  64'(exit_code), 64'd0);
        step(5);
        chk("to_frozen_flags", 64'(flags()), 64'b101011);
        chk("to_frozen_cnt",   64'(cycle_count), 64'd99);

        // pass at RUN cycle 10
        to_run("ps");
        step(10);
        chk("ps_cnt10", 64'(cycle_count), 64'd10);
        store(32'h0000_1000, 32'd1);
        chk("ps_flags", 64'(flags()), 64'b101100);
        chk("ps_cnt",   64'(cycle_count), 64'd10);
        chk("ps_exit",  64'(exit_code), 64'd0);
        step(3);
        chk("ps_hold_cnt", 64'(cycle_count), 64'd10);

        // stores ignored during HOLD, to a wrong address, or with zero data
        do_reset("ig");
        mon_valid = 1'b1;
        mon_addr  = 32'h0000_1000;
        mon_wdata = 32'd1;
        step(4);
        mon_valid = 1'b0;
        chk("ig_hold_store", 64'(flags()), 64'b010000);
        store(32'h0000_1004, 32'd1);
        chk("ig_wrong_addr", 64'(flags()), 64'b010000);
        store(32'h0000_1000, 32'd0);
        chk("ig_zero_data", 64'(flags()), 64'b010000);
        chk("ig_cnt2",      64'(cycle_count), 64'd2);

        // fail code 7 -> exit 3, later stores ignored in DONE
        store(32'h0000_1000, 32'h0000_0007);
        chk("fl_flags", 64'(flags()), 64'b101010);
        chk("fl_exit",  64'(exit_code), 64'd3);
        chk("fl_cnt",   64'(cycle_count), 64'd2);
        store(32'h0000_1000, 32'd1);
        chk("fl_after_flags", 64'(flags()), 64'b101010);
        chk("fl_after_exit",  64'(exit_code), 64'd3);

        // shift is logical: top bit of the code is zero-filled
        to_run("sh");
        store(32'h0000_1000, 32'hFFFF_FFFE);
        chk("sh_flags", 64'(flags()), 64'b101010);
        chk("sh_exit",  64'(exit_code), 64'h7FFF_FFFF);

        // pass on the last cycle wins over timeout
        to_run("pr");
        step(99);
        chk("pr_cnt99", 64'(cycle_count), 64'd99);
        store(32'h0000_1000, 32'd1);
        chk("pr_flags", 64'(flags()), 64'b101100);
        chk("pr_cnt",   64'(cycle_count), 64'd99);

        // asynchronous reset mid-RUN, sequence restarts
        to_run("mr");
        step(50);
        chk("mr_cnt50", 64'(cycle_count), 64'd50);
        #3;
        reset = 1'b0;
        #1;
        chk("mr_async_flags", 64'(flags()), 64'b100000);
        chk("mr_async_cnt",   64'(cycle_count), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        step(3);
        chk("mr_hold3", 64'(flags()), 64'b100000);
        step(1);
        chk("mr_rerun", 64'(flags()), 64'b010000);
        chk("mr_cnt0",  64'(cycle_count), 64'd0);
        step(5);
        chk("mr_cnt5",  64'(cycle_count), 64'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32_test_ctrl.md
RV32_TEST_CTRL -- requirements
Module: rv32_test_ctrl

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 4, the number of cycles core_reset is held after the block leaves reset (range 1..255).
REQ-002 The block SHALL have parameter TIMEOUT, default 100, the maximum number of RUN cycles before a timeout is declared (range 2..2^CNT_W-1).
REQ-003 The block SHALL have parameter CNT_W, default 32, the cycle counter width.
REQ-004 The block SHALL have parameter DATA_W, default 32, the monitored write-data width.
REQ-005 The block SHALL have parameter TOHOST_ADDR, default 32'h0000_1000, the end-of-test mailbox address.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port mon_valid, input, 1 bit: a core store is presented this cycle.
REQ-009 The block SHALL have port mon_addr, input, 32 bits: the store address.
REQ-010 The block SHALL have port mon_wdata, input, DATA_W bits: the store data.
REQ-011 The block SHALL have port core_reset, output, 1 bit: active-high reset to the rv32 core.
REQ-012 The block SHALL have ports running, done, pass, fail and timeout, output, 1 bit each: status flags.
REQ-013 The block SHALL have port cycle_count, output, CNT_W bits: the number of RUN cycles elapsed.
REQ-014 The block SHALL have port exit_code, output, DATA_W bits: the failure code.

Function
REQ-015 The block SHALL use the FSM states HOLD, RUN and DONE, state-encoded in a registered state variable.
REQ-016 HOLD SHALL drive core_reset=1 and decrement an 8-bit hold counter loaded with RST_CYCLES-1 at reset; when the counter is 0 the FSM SHALL go to RUN on the next edge, so core_reset is high for exactly RST_CYCLES rising edges after reset deasserts.
REQ-017 RUN SHALL drive core_reset=0 and running=1, and SHALL increment cycle_count by 1 per cycle starting from 0.
REQ-018 A tohost hit SHALL be defined as mon_valid=1 AND mon_addr==TOHOST_ADDR AND mon_wdata!=0; mon_valid with data 0, mon_valid with any other address, or mon_valid outside RUN SHALL be ignored.
REQ-019 A tohost hit with mon_wdata==1 SHALL set pass=1 and exit_code=0, and the FSM SHALL enter DONE on that edge.
REQ-020 A tohost hit with any other mon_wdata SHALL set fail=1 and exit_code=mon_wdata>>1 (logical shift, zero-filled MSB), and the FSM SHALL enter DONE.
REQ-021 When cycle_count==TIMEOUT-1 in RUN with no tohost hit that cycle, the block SHALL set timeout=1 and fail=1, leave exit_code=0 and enter DONE.
REQ-022 A tohost hit and a timeout condition in the same cycle SHALL resolve to the tohost hit; timeout SHALL stay 0.
REQ-023 DONE SHALL drive done=1, running=0 and core_reset=1 (core frozen), freeze cycle_count, and hold pass, fail, timeout and exit_code until reset; DONE SHALL have no exit except reset.
REQ-024 cycle_count SHALL never exceed TIMEOUT-1 and SHALL never wrap.
REQ-025 pass and fail SHALL never both be 1; exactly one of them SHALL be 1 whenever done=1.
REQ-026 All outputs SHALL be registered or decoded from registered state only, with no combinational path from mon_* to any output.

Reset
REQ-027 On reset=0, asynchronously and regardless of the current state, the block SHALL set state=HOLD, core_reset=1, running=0, done=0, pass=0, fail=0, timeout=0, cycle_count=0, exit_code=0, and hold counter=RST_CYCLES-1.
REQ-028 Reset asserted mid-RUN or in DONE SHALL abort the test, and the full HOLD sequence SHALL restart after reset deasserts.

Verification
REQ-029 Defaults, reset released, no stores -> core_reset high for 4 edges; running=1 for 100 cycles; then timeout=1, fail=1, done=1, cycle_count=99, exit_code=0.
REQ-030 Store to 0x1000 with data 1 at RUN cycle 10 -> next edge pass=1, done=1, core_reset=1, cycle_count frozen at 10, fail=0.
REQ-031 Store to 0x1000 with data 0x0000_0007 -> fail=1, exit_code=3, timeout=0; a second store to 0x1000 with data 1 afterwards -> flags unchanged.
REQ-032 Store data 1 to 0x1004, store data 0 to 0x1000, and a store during HOLD -> all ignored, running stays 1.
REQ-033 Store to 0x1000 with data 1 on the cycle where cycle_count=99 -> pass=1, timeout=0.
REQ-034 Reset pulsed low at RUN cycle 50 -> all outputs clear immediately; after release the HOLD and RUN sequence repeats with cycle_count restarting at 0.
